apb_req_sequencer: RTL

//  Upstream command stage for the APB master. Buffers CPU-side requests in a FIFO, launches

---
 rtl/apb_req_sequencer.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/apb_req_sequencer.sv
// apb_req_sequencer
// Command stage in front of the APB master. CPU-side commands are queued in a
// small FIFO and launched one at a time on the master's user interface with a
// single-cycle transfer pulse. The APB bus is monitored for access completion.
// The result (read data and slave error) is held on a valid/ready response
// channel. A new access launches only when the response slot is empty, so at
// most one access is ever outstanding.
module apb_req_sequencer #(
    parameter int DEPTH  = 4,   // command FIFO entries, power of 2, >= 2
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32   // multiple of 8
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,

    // command channel (CPU side)
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_W-1:0]         cmd_addr,
    input  logic [DATA_W-1:0]         cmd_wdata,
    input  logic [DATA_W/8-1:0]       cmd_strb,
    input  logic [2:0]                cmd_prot,
    input  logic                      cmd_pnse,

    // response channel
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_write,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_error,

    // APB master user interface
    output logic                      transfer,
    output logic                      write_en,
    output logic [ADDR_W-1:0]         waddr,
    output logic [DATA_W-1:0]         wdata,
    output logic [DATA_W/8-1:0]       strb,
    output logic [2:0]                prot,
    output logic                      pnse,

    // APB bus monitor
    input  logic                      PSELx,
    input  logic                      PENABLE,
    input  logic                      PREADY,
    input  logic                      PSLVERR,
    input  logic [DATA_W-1:0]         PRDATA,

    // status
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic                      busy
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int STRB_W = DATA_W / 8;

    // One queued command: everything the master needs for one access.
    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] strb;
        logic [2:0]        prot;
        logic              pnse;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,    // waiting for a queued command and a free response slot
        ST_LAUNCH,  // transfer pulse to the master
        ST_WAIT     // access in flight on the bus
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    cmd_t             fifo_mem [DEPTH];
    cmd_t             cmd_in;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic             push;
    logic             pop;

    assign cmd_in = '{
        write: cmd_write,
        addr:  cmd_addr,
        wdata: cmd_wdata,
        strb:  cmd_strb,
        prot:  cmd_prot,
        pnse:  cmd_pnse
    };

    // Ready depends on the stored level only: a full FIFO never passes a
    // command through, even when an entry is popped in the same cycle.
    assign cmd_ready  = (level != LVL_W'(DEPTH));
    assign push       = cmd_valid & cmd_ready;
    assign fifo_level = level;

    // Storage write port.
    // NOTE: the storage array has no reset; the pointers and level alone
    // decide which entries are meaningful, so clearing the data is wasted logic.
    always_ff @(posedge PCLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= cmd_in;
        end
    end

    // Pointers wrap naturally mod DEPTH; level tracks push/pop balance.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Launch / completion FSM
    // ------------------------------------------------------------------
    state_t state_q;
    state_t state_d;
    logic   done;
    logic   rsp_load;
    cmd_t   cur_q;

    // A completed access on the bus; only meaningful while in WAIT.
    assign done = PSELx & PENABLE & PREADY;

    // State register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic, FIFO pop and response capture strobes.
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        rsp_load = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if ((level != '0) && !rsp_valid) begin
                    pop     = 1'b1;
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (done) begin
                    rsp_load = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign transfer = (state_q == ST_LAUNCH);
    assign busy     = (state_q != ST_IDLE);

    // Field registers: loaded on pop, then held (also after completion) so the
    // master sees stable fields for the whole access.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cur_q <= '0;
        end else if (pop) begin
            cur_q <= fifo_mem[rd_ptr];
        end
    end

    assign write_en = cur_q.write;
    assign waddr    = cur_q.addr;
    assign wdata    = cur_q.wdata;
    assign strb     = cur_q.strb;
    assign prot     = cur_q.prot;
    assign pnse     = cur_q.pnse;

    // ------------------------------------------------------------------
    // Response slot
    // ------------------------------------------------------------------
    // Captured on completion, held until the consumer takes it. Payload is
    // left in place after the handshake; only the valid flag drops.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
        end else if (rsp_load) begin
            rsp_valid <= 1'b1;
            rsp_write <= cur_q.write;
            rsp_rdata <= cur_q.write ? '0 : PRDATA;
            rsp_error <= PSLVERR;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule
